// File: rtl/rv32_pkg.sv
// ----------------------------------------------------------------------------
// rv32 -- shared types for the core's memory-side blocks.
//
// Contents:
//   word         32-bit machine word
//   arb_state_t  memory arbiter state (IDLE, I_BUSY, D_BUSY)
//   arb_grant_t  which requester owned the most recent grant
//   mem_req_t    one bus transaction's fields (we, be, addr, wdata)
//   fetch_req()  builds the bus fields for an instruction fetch
// ----------------------------------------------------------------------------
package rv32;

    typedef logic [31:0] word;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } arb_grant_t;

    typedef struct packed {
        logic       we;
        logic [3:0] be;
        word        addr;
        word        wdata;
    } mem_req_t;

    localparam logic [3:0] BE_WORD = 4'hF;

    // Fetches are always full-word reads with no write data.
    function automatic mem_req_t fetch_req(input word addr);
        mem_req_t req;
        req.we    = 1'b0;
        req.be    = BE_WORD;
        req.addr  = addr;
        req.wdata = '0;
        return req;
    endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// ----------------------------------------------------------------------------
// mem_arb_timeout -- watchdog counter for a bus transaction that never ends.
//
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
//
// Ports:
//   clk        in   core clock
//   rst_n      in   synchronous active-low reset
//   i_clear    in   restart the count (new grant)
//   i_enable   in   count this cycle (BUSY without bus completion)
//   o_expired  out  count has reached LIMIT-1
// ----------------------------------------------------------------------------
module mem_arb_timeout #(
    parameter int unsigned LIMIT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    // One spare count value so the increment on the expiry cycle never
    // aliases back onto LIMIT-1 before the next grant clears it.
    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_expired = (r_count == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter -- shares the single memory bus between instruction fetch
// (ibus, read-only) and load/store (dbus). One transaction outstanding at a
// time, round-robin between simultaneous requesters, fetch flush support and
// bus-error reporting.
//
// Build option:
//   MEM_ARB_TIMEOUT_EN  when defined, a transaction that sees no bus_ack /
//                       bus_err for TIMEOUT_CYCLES BUSY cycles completes as a
//                       forced error. When undefined, BUSY waits indefinitely.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   i_req/i_addr/i_flush          fetch request, address, redirect
//   i_ack/i_rdata/i_err           fetch completion, data, error
//   d_req/d_we/d_be/d_addr/d_wdata data request and its fields
//   d_ack/d_rdata/d_err           data completion, data, error
//   bus_req/bus_we/bus_be/bus_addr/bus_wdata  registered bus request
//   bus_ack/bus_rdata/bus_err     bus completion
//   busy                          arbiter is not IDLE
// ----------------------------------------------------------------------------
module mem_arbiter
    import rv32::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_flush,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    output logic        i_err,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,

    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err,

    output logic        busy
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    arb_state_t r_state;
    arb_grant_t r_last_grant;
    logic       r_drop;      // in-flight fetch was flushed; swallow its ack
    mem_req_t   r_bus;

    logic w_busy;
    logic w_bus_done;
    logic w_timeout;
    logic w_done;
    logic w_err;
    logic w_i_req_q;
    logic w_arb_open;
    logic w_i_elig;
    logic w_d_elig;
    logic w_grant_i;
    logic w_grant_d;

    assign w_busy     = (r_state != IDLE);
    assign w_bus_done = w_busy & (bus_ack | bus_err);

`ifdef MEM_ARB_TIMEOUT_EN
    logic w_expired;

    mem_arb_timeout #(
        .LIMIT     (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_grant_i | w_grant_d),
        .i_enable  (w_busy & ~w_bus_done),
        .o_expired (w_expired)
    );

    assign w_timeout = w_busy & ~w_bus_done & w_expired;
`else
    assign w_timeout = 1'b0;
`endif

    // A forced timeout is reported exactly like a bus error.
    assign w_done = w_bus_done | w_timeout;
    assign w_err  = bus_err | w_timeout;

    // Completion is combinational from the bus so the requester sees its ack
    // in the same cycle as bus_ack. A flush, either earlier in the
    // transaction (r_drop) or in this very cycle, hides the fetch response.
    assign i_ack   = w_done & (r_state == I_BUSY) & ~r_drop & ~i_flush;
    assign i_err   = i_ack & w_err;
    assign i_rdata = bus_rdata;

    assign d_ack   = w_done & (r_state == D_BUSY);
    assign d_err   = d_ack & w_err;
    assign d_rdata = bus_rdata;

    // Arbitration happens in IDLE or in a completion cycle. The requester
    // that is completing still holds its req this cycle, so it is masked out;
    // a same-requester re-request therefore always sees one IDLE cycle.
    assign w_i_req_q  = i_req & ~i_flush;
    assign w_arb_open = ~w_busy | w_done;
    assign w_i_elig   = w_arb_open & w_i_req_q & (r_state != I_BUSY);
    assign w_d_elig   = w_arb_open & d_req & (r_state != D_BUSY);

    assign w_grant_i  = w_i_elig & (~w_d_elig | (r_last_grant == GRANT_D));
    assign w_grant_d  = w_d_elig & ~w_grant_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_D;
            r_drop       <= 1'b0;
            r_bus        <= '0;
        end else begin
            if (w_grant_i) begin
                r_state      <= I_BUSY;
                r_last_grant <= GRANT_I;
                r_bus        <= fetch_req(i_addr);
            end else if (w_grant_d) begin
                r_state      <= D_BUSY;
                r_last_grant <= GRANT_D;
                r_bus        <= '{we: d_we, be: d_be, addr: d_addr, wdata: d_wdata};
            end else if (w_done) begin
                r_state      <= IDLE;
            end

            if (w_done) begin
                r_drop <= 1'b0;
            end else if ((r_state == I_BUSY) && i_flush) begin
                r_drop <= 1'b1;
            end
        end
    end

    assign bus_req   = w_busy;
    assign bus_we    = r_bus.we;
    assign bus_be    = r_bus.be;
    assign bus_addr  = r_bus.addr;
    assign bus_wdata = r_bus.wdata;
    assign busy      = w_busy;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the core's single memory bus between instruction fetch (ibus, read-only) and load/store (dbus, read/write).
- Sits between the fetch/LSU stages and the memory/peripheral interconnect.
- At most one bus transaction is outstanding at a time.
- Honours fetch flushes raised by pipeline control on branch or trap redirect.
- Reports bus errors back to the requester so the pipeline can raise an access-fault trap.

Parameters:
- TIMEOUT_CYCLES, 256, cycles in BUSY without bus_ack/bus_err before forced error completion; used only with the optional feature.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, synchronous, active-low
- i_req  in  1  fetch request; held with i_addr until i_ack
- i_addr  in  32  fetch address (rv32::word)
- i_flush  in  1  fetch redirect; drops any outstanding fetch response
- i_ack  out  1  fetch complete; i_rdata/i_err valid
- i_rdata  out  32  fetch data
- i_err  out  1  fetch bus error
- d_req  in  1  data request; held with d_we/d_be/d_addr/d_wdata until d_ack
- d_we  in  1  1 = store
- d_be  in  4  byte enables
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_ack  out  1  data complete
- d_rdata  out  32  load data
- d_err  out  1  data bus error
- bus_req  out  1  bus request; fields stable while high
- bus_we  out  1  write
- bus_be  out  4  byte enables (4'hF for fetch)
- bus_addr  out  32  address
- bus_wdata  out  32  write data (0 for fetch)
- bus_ack  in  1  transaction done; bus_rdata valid
- bus_rdata  in  32  read data
- bus_err  in  1  transaction done with error
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low at posedge):
  - state = IDLE, last_grant = DATA, drop = 0.
  - All bus_* field registers 0; bus_req = 0.
  - i_ack, d_ack, i_err, d_err = 0.
- States: IDLE, I_BUSY, D_BUSY.
- Effective requests:
  - i_req_q = i_req & ~i_flush.
  - d_req is used as-is.
- Arbitration (IDLE, or completion cycle):
  - One effective requester: grant it.
  - Both: grant the one that is not last_grant (round-robin).
  - On grant: register the bus_* fields, set last_grant, and go to I_BUSY or D_BUSY at the next edge.
- bus_req = (state != IDLE); all fields come from registers.
  - Latency: req at cycle N, bus_req at N+1; with a same-cycle bus_ack, the requester's ack is also at N+1.
- Completion: done = bus_ack | bus_err while BUSY.
  - Requester ack is combinational from the bus: i_ack = done & I_BUSY & ~drop; d_ack = done & D_BUSY.
  - rdata passes bus_rdata through; err = bus_err.
  - bus_ack and bus_err together: treat as error.
- Back-to-back:
  - In the completion cycle, only the other requester is eligible; the just-acked requester's req is ignored that cycle.
  - If the other requester is eligible, go directly to its BUSY state with new fields; otherwise go to IDLE.
  - A same-requester re-request always passes through one IDLE cycle.
- Flush:
  - i_flush while I_BUSY sets drop; the bus transaction still completes, with i_ack/i_err suppressed.
  - drop clears on completion.
  - i_flush in the completion cycle also suppresses i_ack.
  - i_flush while D_BUSY or IDLE has no effect on dbus.
- Reset mid-transaction: IDLE at the next edge, and bus_req falls. A late bus_ack after that is ignored.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on grant and increments each BUSY cycle without done.
  - When it reaches TIMEOUT_CYCLES-1 with no done, the transaction completes as a forced error: requester ack + err = 1, bus_req drops next cycle, then normal arbitration.
  - A bus_ack arriving after a forced timeout is ignored.
- Not defined: no counter; BUSY waits indefinitely for the bus.

Decomposition:
- Package rv32:
  - arb_state_t enum {IDLE, I_BUSY, D_BUSY}
  - arb_grant_t enum {GRANT_I, GRANT_D}
  - mem_req_t struct {we, be[3:0], addr, wdata}
- Sub-module mem_arb_timeout: counter with clear/enable/expired, instantiated only under MEM_ARB_TIMEOUT_EN.

Test Plan:
- Single fetch:
  - Stimulus: i_req=1, i_addr=0x0000_0100; bus_ack one cycle after bus_req with rdata 0x0000_0013.
  - Response: bus_addr=0x100, be=4'hF, we=0; i_ack for one cycle with i_rdata=0x13; d_ack never.
- Simultaneous requests from reset:
  - Stimulus: i_req and d_req both high; d_we=1, d_be=4'b0011, d_addr=0x2000_0004, d_wdata=0xBEEF.
  - Response: fetch granted first; on its ack the store is issued back-to-back with no IDLE cycle between.
  - Next simultaneous pair after a data grant: fetch wins.
- Flush mid-fetch:
  - Stimulus: i_flush pulses while I_BUSY; bus_ack arrives 3 cycles later.
  - Response: no i_ack; state returns to IDLE; a new i_req to 0x400 is then served normally.
- Bus error:
  - Stimulus: d_req load to 0xFFFF_0000; bus_err=1.
  - Response: d_ack=1 and d_err=1 in the same cycle; d_rdata is don't-care.
- Reset mid-transaction:
  - Stimulus: rst_n low for 1 cycle while D_BUSY.
  - Response: bus_req=0 and busy=0 after the edge; a late bus_ack produces no d_ack.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8):
  - Stimulus: fetch issued; bus never acks.
  - Response: i_ack and i_err asserted in the 8th BUSY cycle; bus_req low the next cycle.
